alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL provide parameter: WIDTH, default 32, operand/result width (power of two, 8..64).
REQ-002 SHALL provide parameter: SHW, default $clog2(WIDTH), shift-amount width taken from B[SHW-1:0].
REQ-003 SHALL provide port: clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL provide port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL provide port: in_valid  input  1  operation request.
REQ-006 SHALL provide port: in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL provide port: A, B  input  WIDTH each  operands.
REQ-008 SHALL provide port: Op  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1001 SLL, 1010 SRL, 1011 SRA, 1100 MUL; all others illegal.
REQ-009 SHALL provide port: out_valid  output  1  result registers hold a valid result.
REQ-010 SHALL provide port: out_ready  input  1  consumer takes the result.
REQ-011 SHALL provide port: Result  output  WIDTH  registered result.
REQ-012 SHALL provide port: Carryout, Overflow, Zero, Set, Err  output  1 each  registered flags.

Function
REQ-013 SHALL accept a request on a cycle where in_valid && in_ready, capturing A, B, Op.
REQ-014 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready), so a new request and a result drain may coincide.
REQ-015 SHALL implement FSM IDLE -> (MUL accepted) BUSY -> IDLE; all non-MUL ops stay in IDLE.
REQ-016 SHALL present non-MUL results with out_valid high on the cycle after acceptance (latency 1).
REQ-017 SHALL compute MUL by shift-add over exactly WIDTH BUSY cycles; out_valid rises on the cycle after the last iteration (latency WIDTH+1); Result = low WIDTH bits of A*B.
REQ-018 SHALL hold Result and all flags stable while out_valid && !out_ready; clear out_valid on out_valid && out_ready unless a new result loads the same cycle.
REQ-019 SHALL compute ADD as A+B, SUB as A+~B+1; Carryout = carry out of MSB (SUB: 1 = no borrow); Overflow = signed overflow; both 0 for every other op.
REQ-020 SHALL compute SLT: Result = {0..,Set}, Set = signed (A<B) from SUB sign XOR overflow; Set = 0 for other ops.
REQ-021 SHALL shift by B[SHW-1:0] only; SLL/SRL zero-fill, SRA sign-fill; shift by 0 returns A.
REQ-022 SHALL set Zero = (Result == 0) for every op, including MUL and illegal.
REQ-023 SHALL for illegal Op complete in 1 cycle with Result 0, Zero 1, Err 1, other flags 0; Err 0 for legal ops.
REQ-024 SHALL ignore in_valid while BUSY (in_ready low); operands are not re-sampled mid-multiply.

Reset
REQ-025 SHALL on rst_n low asynchronously force state IDLE, out_valid 0, Result 0, Carryout/Overflow/Set/Err 0, Zero 1, multiplier counter/accumulator 0.
REQ-026 SHALL abandon an in-flight MUL on reset with no result emitted; in_ready high on the first clock edge after rst_n deasserts.

Configuration
REQ-027 SHALL compile MUL and BUSY state only when ALU_SEQ_MUL_EN is defined.
REQ-028 SHALL, without ALU_SEQ_MUL_EN, treat Op 1100 as illegal (REQ-023) and never leave IDLE.

Structure
REQ-029 SHALL place opcode constants, the opcode enum and FSM state enum in package alu_seq_pkg.
REQ-030 SHALL implement the iterative multiplier as sub-module alu_mul_iter (start, A, B -> done, product), instantiated only under ALU_SEQ_MUL_EN.

Verification (WIDTH=32)
REQ-031 SHALL verify ADD 0x7FFFFFFF+0x00000001 -> next cycle Result 0x80000000, Overflow 1, Carryout 0, Zero 0.
REQ-032 SHALL verify SUB 5-5 -> Result 0, Zero 1, Carryout 1; SLT A=0xFFFFFFFF B=1 -> Result 1, Set 1.
REQ-033 SHALL verify SRA A=0x80000000 B=4 -> 0xF8000000; SRL same -> 0x08000000; SLL B=0x21 -> A<<1.
REQ-034 SHALL verify MUL 0x00010000*0x00010001 (MUL_EN) -> in_ready low 32 cycles, out_valid at cycle 33, Result 0x00010000, Zero 0.
REQ-035 SHALL verify out_ready held low 5 cycles after ADD 3+4 -> Result 7 stable, in_ready low; out_ready high with new in_valid same cycle -> back-to-back accept.
REQ-036 SHALL verify rst_n pulse at BUSY cycle 10 -> out_valid never asserts, outputs at reset values; Op 1111 -> Err 1, Zero 1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode, FSM state and flag-bundle definitions for alu_seq.
package alu_seq_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_SLL = 4'b1001,
    OP_SRL = 4'b1010,
    OP_SRA = 4'b1011,
    OP_MUL = 4'b1100
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic set;
    logic err;
  } flags_t;

  localparam flags_t FLAGS_RST = '{carry: 1'b0, ovf: 1'b0, zero: 1'b1, set: 1'b0, err: 1'b0};

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one partial product per cycle for WIDTH cycles after start_i.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_c,
  output logic [WIDTH-1:0] product_c
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, addend_c;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // done/product describe the final iteration so the caller can load on the same edge
  assign addend_c  = b_q[0] ? a_q : '0;
  assign product_c = acc_q + addend_c;
  assign done_c    = busy_q && (cnt_q == LAST);

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      a_d    = a_i;
      b_d    = b_i;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d  = product_c;
      a_d    = a_q << 1;
      b_d    = b_q >> 1;
      cnt_d  = cnt_q + CW'(1);
      busy_d = !done_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Valid/ready sequential ALU; single-cycle ops plus an iterative MUL that is
// compiled in only when ALU_SEQ_MUL_EN is defined (otherwise opcode 1100 is illegal).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Carryout,
  output logic             Overflow,
  output logic             Zero,
  output logic             Set,
  output logic             Err
);

  localparam int unsigned SW = WIDTH + 1;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;

  logic             ready_c, accept_c, is_mul_c, is_sub_c, ovf_c;
  logic [WIDTH-1:0] b_eff_c, alu_res_c;
  logic [SW-1:0]    sum_c;
  logic [SHW-1:0]   shamt_c;
  flags_t           alu_flags_c;

  assign ready_c  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept_c = in_valid && ready_c;

`ifdef ALU_SEQ_MUL_EN
  logic             mul_start_c, mul_done_c;
  logic [WIDTH-1:0] mul_prod_c;

  assign is_mul_c    = (Op == OP_MUL);
  assign mul_start_c = accept_c && is_mul_c;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start_c),
    .a_i       (A),
    .b_i       (B),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c)
  );
`else
  assign is_mul_c = 1'b0;
`endif

  // SUB and SLT share the adder as A + ~B + 1
  assign shamt_c  = B[SHW-1:0];
  assign is_sub_c = (Op == OP_SUB) || (Op == OP_SLT);
  assign b_eff_c  = is_sub_c ? ~B : B;
  assign sum_c    = {1'b0, A} + {1'b0, b_eff_c} + SW'(is_sub_c);
  assign ovf_c    = (A[WIDTH-1] == b_eff_c[WIDTH-1]) && (sum_c[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    alu_res_c   = '0;
    alu_flags_c = '0;
    case (Op)
      OP_AND: alu_res_c = A & B;
      OP_OR:  alu_res_c = A | B;
      OP_ADD, OP_SUB: begin
        alu_res_c         = sum_c[WIDTH-1:0];
        alu_flags_c.carry = sum_c[WIDTH];
        alu_flags_c.ovf   = ovf_c;
      end
      OP_SLT: begin
        alu_flags_c.set = sum_c[WIDTH-1] ^ ovf_c;
        alu_res_c       = WIDTH'(alu_flags_c.set);
      end
      OP_SLL: alu_res_c = A << shamt_c;
      OP_SRL: alu_res_c = A >> shamt_c;
      OP_SRA: alu_res_c = $unsigned($signed(A) >>> shamt_c);
      default: alu_flags_c.err = 1'b1;
    endcase
    alu_flags_c.zero = (alu_res_c == '0);
  end

  // Output registers load on single-cycle accept or multiplier completion
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c && is_mul_c) begin
          state_d = BUSY;
        end else if (accept_c) begin
          result_d    = alu_res_c;
          flags_d     = alu_flags_c;
          out_valid_d = 1'b1;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      BUSY: begin
        if (mul_done_c) begin
          state_d      = IDLE;
          result_d     = mul_prod_c;
          flags_d      = '0;
          flags_d.zero = (mul_prod_c == '0);
          out_valid_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= FLAGS_RST;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready  = ready_c;
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Carryout  = flags_q.carry;
  assign Overflow  = flags_q.ovf;
  assign Zero      = flags_q.zero;
  assign Set       = flags_q.set;
  assign Err       = flags_q.err;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=32): transaction-level reference model compared every cycle,
// plus directed vectors with literal expectations. Follows ALU_SEQ_MUL_EN like the RTL.
module tb_alu_seq;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [3:0]    Op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Result;
  logic          Carryout, Overflow, Zero, Set, Err;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Op        (Op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Carryout  (Carryout),
    .Overflow  (Overflow),
    .Zero      (Zero),
    .Set       (Set),
    .Err       (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: plain arithmetic on the operands; flags packed {carry, ovf, zero, set, err}
  function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [4:0] f);
    longint sa, sb, sd;
    logic c, v, s, e;
    logic [32:0] wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; s = 1'b0; e = 1'b0; r = '0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        wide = 33'(a) + 33'(b);
        r = wide[31:0];
        c = wide[32];
        sd = sa + sb;
        v = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      end
      4'b0110: begin
        r = a - b;
        c = (a >= b);
        sd = sa - sb;
        v = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      end
      4'b0111: begin
        s = ($signed(a) < $signed(b));
        r = {31'b0, s};
      end
      4'b1001: r = a << b[4:0];
      4'b1010: r = a >> b[4:0];
      4'b1011: r = $signed(a) >>> b[4:0];
      default: e = 1'b1;
    endcase
    f = {c, v, (r == 32'd0), s, e};
  endfunction

  logic [31:0] m_res, m_pend, r_tmp;
  logic [4:0]  m_flags, f_tmp;
  logic        m_valid, m_rdy;
  int          m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res   = '0;
      m_flags = 5'b00100;
      m_valid = 1'b0;
      m_busy  = 0;
      m_pend  = '0;
    end else begin
      m_rdy = (m_busy == 0) && (!m_valid || out_ready);
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_res   = m_pend;
          m_flags = {2'b00, (m_pend == 32'd0), 2'b00};
          m_valid = 1'b1;
        end
      end else if (in_valid && m_rdy) begin
`ifdef ALU_SEQ_MUL_EN
        if (Op == 4'b1100) begin
          m_pend = A * B;
          m_busy = W;
        end else begin
          model_op(Op, A, B, r_tmp, f_tmp);
          m_res = r_tmp; m_flags = f_tmp; m_valid = 1'b1;
        end
`else
        model_op(Op, A, B, r_tmp, f_tmp);
        m_res = r_tmp; m_flags = f_tmp; m_valid = 1'b1;
`endif
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_in_ready", {31'b0, in_ready}, {31'b0, (m_busy == 0) && (!m_valid || out_ready)});
    check("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("cyc_result", Result, m_res);
    check("cyc_flags", {27'b0, Carryout, Overflow, Zero, Set, Err}, {27'b0, m_flags});
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; Op = op; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_res(input string name, input logic [31:0] res, input logic [4:0] flags);
    @(negedge clk);
    check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({name, "_res"}, Result, res);
    check({name, "_flags"}, {27'b0, Carryout, Overflow, Zero, Set, Err}, {27'b0, flags});
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Op = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_result", Result, 32'd0);
    check("rst_flags", {27'b0, Carryout, Overflow, Zero, Set, Err}, 32'b00100);
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001); expect_res("add_ovf",  32'h8000_0000, 5'b01000);
    issue(4'b0110, 32'd5, 32'd5);                 expect_res("sub_eq",   32'h0000_0000, 5'b10100);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1);         expect_res("slt_neg",  32'h0000_0001, 5'b00010);
    issue(4'b1011, 32'h8000_0000, 32'd4);         expect_res("sra",      32'hF800_0000, 5'b00000);
    issue(4'b1010, 32'h8000_0000, 32'd4);         expect_res("srl",      32'h0800_0000, 5'b00000);
    issue(4'b1001, 32'h1234_5678, 32'h21);        expect_res("sll_mask", 32'h2468_ACF0, 5'b00000);
    issue(4'b1011, 32'h8000_0000, 32'h20);        expect_res("sra_zero", 32'h8000_0000, 5'b00000);
    issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00); expect_res("and",      32'hF000_F000, 5'b00000);
    issue(4'b0001, 32'h0F0F_0000, 32'h0000_00F0); expect_res("or",       32'h0F0F_00F0, 5'b00000);
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1);         expect_res("add_wrap", 32'h0000_0000, 5'b10100);
    issue(4'b0110, 32'd3, 32'd5);                 expect_res("sub_brw",  32'hFFFF_FFFE, 5'b00000);
    issue(4'b0110, 32'h8000_0000, 32'd1);         expect_res("sub_ovf",  32'h7FFF_FFFF, 5'b11000);
    issue(4'b0111, 32'd1, 32'hFFFF_FFFF);         expect_res("slt_pos",  32'h0000_0000, 5'b00100);
    issue(4'b1111, 32'h1234, 32'h5678);           expect_res("illegal_f", 32'h0000_0000, 5'b00101);
    issue(4'b0011, 32'h1, 32'h1);                 expect_res("illegal_3", 32'h0000_0000, 5'b00101);

    // Backpressure: result must hold and block new requests
    out_ready = 1'b0;
    issue(4'b0010, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_res", Result, 32'd7);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b1; Op = 4'b0001; A = 32'd1; B = 32'd2;
    @(negedge clk);
    check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_res("b2b_or", 32'd3, 5'b00000);

`ifdef ALU_SEQ_MUL_EN
    issue(4'b1100, 32'h0001_0000, 32'h0001_0001);
    in_valid = 1'b1; Op = 4'b0010; A = 32'd1; B = 32'd1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      check("mul_busy_in_ready", {31'b0, in_ready}, 32'd0);
      check("mul_busy_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;
      if (i == 32) in_valid = 1'b0;
    end
    expect_res("mul", 32'h0001_0000, 5'b00000);
    issue(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (32) begin @(posedge clk); #1; end
    expect_res("mul_neg", 32'h0000_0001, 5'b00000);
`else
    issue(4'b1100, 32'h0001_0000, 32'h0001_0001); expect_res("mul_illegal", 32'h0000_0000, 5'b00101);
`endif

    // Reset mid-operation: nothing may emerge afterwards
    out_ready = 1'b0;
    issue(4'b1100, 32'd3, 32'd5);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst2_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst2_result", Result, 32'd0);
    check("rst2_flags", {27'b0, Carryout, Overflow, Zero, Set, Err}, 32'b00100);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst2_no_result", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
